pipeline_ctrl: RTL and testbench

Hazard and stall controller for the five-stage RV32I pipeline. Each cycle it computes the load and flush enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Inputs are the memory handshakes, load-use hazard information and branch resolution from EX. It holds a redirect target across outstanding fetches and keeps stall and flush statistics.

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_sat_counter.sv | 37 +++
 rtl/pipeline_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    // Default width of the saturating statistics counters.
    localparam int CNT_W_DEFAULT = 32;

    // All-zero control word; also the idle value of the redirect path.
    localparam logic [31:0] NOP_CTRL = 32'h0000_0000;

    // RUN: normal flow. SQUASH: redirect latched, stale fetch still outstanding.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } pc_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous reset.
module sat_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Step by one when enabled, sticking at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline: produces
// per-register load/flush enables, the PC redirect, and stall/flush statistics.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    pc_ctrl_state_t state_q;
    pc_ctrl_state_t state_d;
    logic [31:0]    tgt_q;
    logic [31:0]    tgt_d;

    logic mem_stall;
    logic fetch_stall;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign mem_stall   = dmem_req & ~dmem_resp;
    assign fetch_stall = ~imem_resp;
    assign load_use    = ex_mem_read & (ex_rd != 5'd0) &
                         ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // State and latched redirect target; reset drops any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            tgt_q   <= NOP_CTRL;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // Enter SQUASH on a taken branch that meets a stalled fetch; leave once the fetch returns.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_RUN: begin
                if (!mem_stall && br_taken && fetch_stall) begin
                    state_d = ST_SQUASH;
                    tgt_d   = br_target;
                end
            end
            ST_SQUASH: begin
                if (imem_resp) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Prioritised hazard resolution into load/flush enables and counter increments.
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = NOP_CTRL;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!rst) begin
            redirect_pc = br_target;
            if (state_q == ST_SQUASH) begin
                redirect_pc = tgt_q;
                load_pc     = imem_resp;
                pc_redirect = imem_resp;
                load_if_id  = 1'b1;
                flush_if_id = 1'b1;
                load_id_ex  = ~mem_stall;
                load_ex_mem = ~mem_stall;
                load_mem_wb = ~mem_stall;
                stall_inc   = 1'b1;
            end else begin
                stall_inc = mem_stall | load_use | fetch_stall;
                if (mem_stall) begin
                    load_pc = 1'b0;
                end else if (br_taken) begin
                    flush_inc   = 1'b1;
                    load_pc     = ~fetch_stall;
                    pc_redirect = ~fetch_stall;
                    load_if_id  = 1'b1;
                    flush_if_id = 1'b1;
                    load_id_ex  = 1'b1;
                    flush_id_ex = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                end else if (load_use) begin
                    load_id_ex  = 1'b1;
                    flush_id_ex = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                end else if (fetch_stall) begin
                    load_if_id  = 1'b1;
                    flush_if_id = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                end else begin
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table vectors, hand-written
// multi-cycle sequences and random traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    typedef struct {
        logic        imem_resp;
        logic        dmem_req;
        logic        dmem_resp;
        logic        ex_mem_read;
        logic [4:0]  ex_rd;
        logic [4:0]  id_rs1;
        logic [4:0]  id_rs2;
        logic        br_taken;
        logic [31:0] br_target;
    } stim_t;

    typedef struct {
        logic [4:0]  loads;
        logic [1:0]  flushes;
        logic        red;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             imem_resp = 1'b1;
    logic             dmem_req = 1'b0;
    logic             dmem_resp = 1'b0;
    logic             ex_mem_read = 1'b0;
    logic [4:0]       ex_rd = '0;
    logic [4:0]       id_rs1 = '0;
    logic [4:0]       id_rs2 = '0;
    logic             br_taken = 1'b0;
    logic [31:0]      br_target = '0;
    logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             flush_if_id, flush_id_ex, pc_redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int vec_count = 0;
    int miss_count = 0;

    // Model state: whether a redirect is pending behind a stale fetch, plus statistics.
    bit          m_pending = 1'b0;
    logic [31:0] m_tgt = '0;
    longint      m_stall = 0;
    longint      m_flush = 0;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_resp    (imem_resp),
        .dmem_req     (dmem_req),
        .dmem_resp    (dmem_resp),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t mkStim(logic im, logic dq, logic dr, logic mr,
                                     logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                                     logic br, logic [31:0] tg);
        stim_t s;
        s.imem_resp = im;  s.dmem_req = dq;  s.dmem_resp = dr;
        s.ex_mem_read = mr; s.ex_rd = rd;   s.id_rs1 = r1;  s.id_rs2 = r2;
        s.br_taken = br;   s.br_target = tg;
        return s;
    endfunction

    function automatic exp_t mkExp(logic [4:0] ld, logic [1:0] fl, logic rd, logic [31:0] pc);
        exp_t e;
        e.loads = ld; e.flushes = fl; e.red = rd; e.rpc = pc;
        return e;
    endfunction

    // Expected outputs: decide how many upstream registers are held and where a bubble enters.
    function automatic exp_t modelOutputs(stim_t s);
        exp_t e;
        bit   ms;
        bit   fs;
        bit   lu;
        int   hold;
        ms = s.dmem_req && !s.dmem_resp;
        fs = !s.imem_resp;
        lu = s.ex_mem_read && (s.ex_rd != 0) && (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
        e.flushes = 2'b00;
        e.red = 1'b0;
        e.rpc = s.br_target;
        hold = 0;
        if (m_pending) begin
            e.rpc = m_tgt;
            e.red = s.imem_resp;
            e.flushes = 2'b10;
            e.loads = {s.imem_resp, 1'b1, {3{!ms}}};
        end else if (ms) begin
            e.loads = 5'b00000;
        end else begin
            if (s.br_taken) begin
                hold = fs ? 1 : 0;
                e.flushes = 2'b11;
                e.red = !fs;
            end else if (lu) begin
                hold = 2;
                e.flushes = 2'b01;
            end else if (fs) begin
                hold = 1;
                e.flushes = 2'b10;
            end
            e.loads = 5'b11111 >> hold;
        end
        return e;
    endfunction

    // Advance the model across one clock edge.
    task automatic modelStep(stim_t s);
        bit ms;
        bit fs;
        bit lu;
        ms = s.dmem_req && !s.dmem_resp;
        fs = !s.imem_resp;
        lu = s.ex_mem_read && (s.ex_rd != 0) && (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
        if ((m_pending || ms || lu || fs) && m_stall < CNT_MAX) m_stall++;
        if (m_pending) begin
            if (s.imem_resp) m_pending = 1'b0;
        end else if (!ms && s.br_taken) begin
            if (m_flush < CNT_MAX) m_flush++;
            if (fs) begin
                m_pending = 1'b1;
                m_tgt = s.br_target;
            end
        end
    endtask

    task automatic modelReset();
        m_pending = 1'b0;
        m_tgt = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(exp_t e, string tag);
        checkVal({tag, ".loads"}, 64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 64'(e.loads));
        checkVal({tag, ".flushes"}, 64'({flush_if_id, flush_id_ex}), 64'(e.flushes));
        checkVal({tag, ".pc_redirect"}, 64'(pc_redirect), 64'(e.red));
        checkVal({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(e.rpc));
        checkVal({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
        checkVal({tag, ".flush_count"}, 64'(flush_count), 64'(m_flush));
    endtask

    task automatic drive(stim_t s);
        imem_resp = s.imem_resp;   dmem_req = s.dmem_req;  dmem_resp = s.dmem_resp;
        ex_mem_read = s.ex_mem_read; ex_rd = s.ex_rd;      id_rs1 = s.id_rs1;
        id_rs2 = s.id_rs2;         br_taken = s.br_taken;  br_target = s.br_target;
    endtask

    // One functional cycle: drive at the falling edge, check mid-cycle, then step the model.
    task automatic applyStimulus(stim_t s, string tag);
        @(negedge clk);
        rst = 1'b0;
        drive(s);
        #1;
        if (m_pending && s.br_taken) begin
            vec_count++;
            miss_count++;
            $display("[TB] FAIL %s.br_in_squash: got 1, expected 0", tag);
        end
        checkOutput(modelOutputs(s), tag);
        modelStep(s);
    endtask

    // Hold reset for a number of cycles, checking every output is forced low.
    task automatic holdReset(int cycles, stim_t s, string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1'b1;
            drive(s);
            #1;
            modelReset();
            checkOutput(mkExp(5'b00000, 2'b00, 1'b0, 32'h0), tag);
        end
    endtask

    vec_t  table_v[12];
    stim_t idle;
    stim_t s;
    longint base;

    initial begin
        idle = mkStim(1, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_0000);

        table_v[0]  = '{"idle",        mkStim(1,0,0,0, 0,0,0, 0,32'hDEAD_0000), mkExp(5'b11111,2'b00,0,32'hDEAD_0000)};
        table_v[1]  = '{"lu_rs2",      mkStim(1,0,0,1, 5,3,5, 0,32'h0000_0040), mkExp(5'b00111,2'b01,0,32'h0000_0040)};
        table_v[2]  = '{"lu_x0",       mkStim(1,0,0,1, 0,0,0, 0,32'h0000_0044), mkExp(5'b11111,2'b00,0,32'h0000_0044)};
        table_v[3]  = '{"lu_rs1",      mkStim(1,0,0,1, 9,9,2, 0,32'h0000_0048), mkExp(5'b00111,2'b01,0,32'h0000_0048)};
        table_v[4]  = '{"no_load",     mkStim(1,0,0,0, 9,9,9, 0,32'h0000_004C), mkExp(5'b11111,2'b00,0,32'h0000_004C)};
        table_v[5]  = '{"branch",      mkStim(1,0,0,0, 0,0,0, 1,32'h0000_0100), mkExp(5'b11111,2'b11,1,32'h0000_0100)};
        table_v[6]  = '{"fetch_stall", mkStim(0,0,0,0, 0,0,0, 0,32'h0000_0104), mkExp(5'b01111,2'b10,0,32'h0000_0104)};
        table_v[7]  = '{"mem_stall",   mkStim(1,1,0,0, 0,0,0, 0,32'h0000_0108), mkExp(5'b00000,2'b00,0,32'h0000_0108)};
        table_v[8]  = '{"mem_done",    mkStim(1,1,1,0, 0,0,0, 0,32'h0000_010C), mkExp(5'b11111,2'b00,0,32'h0000_010C)};
        table_v[9]  = '{"all_hazards", mkStim(0,1,0,1, 4,4,4, 0,32'h0000_0110), mkExp(5'b00000,2'b00,0,32'h0000_0110)};
        table_v[10] = '{"br_over_lu",  mkStim(1,0,0,1, 6,6,1, 1,32'h0000_0114), mkExp(5'b11111,2'b11,1,32'h0000_0114)};
        table_v[11] = '{"lu_over_fs",  mkStim(0,0,0,1, 7,1,7, 0,32'h0000_0118), mkExp(5'b00111,2'b01,0,32'h0000_0118)};

        holdReset(2, mkStim(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_1234), "reset");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(table_v[i].s, table_v[i].name);
            checkVal({table_v[i].name, ".tbl_loads"},
                     64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 64'(table_v[i].e.loads));
            checkVal({table_v[i].name, ".tbl_flushes"}, 64'({flush_if_id, flush_id_ex}), 64'(table_v[i].e.flushes));
            checkVal({table_v[i].name, ".tbl_redirect"}, 64'(pc_redirect), 64'(table_v[i].e.red));
            checkVal({table_v[i].name, ".tbl_rpc"}, 64'(redirect_pc), 64'(table_v[i].e.rpc));
        end

        // Redirect behind a stalled fetch: three squash cycles, then redirect on the response.
        applyStimulus(idle, "pre_sq");
        base = m_stall;
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0200), "sq_enter");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000), "sq_wait");
            checkVal("sq_wait.flush_if_id", 64'(flush_if_id), 64'd1);
        end
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000), "sq_resp");
        checkVal("sq_resp.load_pc", 64'(load_pc), 64'd1);
        checkVal("sq_resp.redirect_pc", 64'(redirect_pc), 64'h200);
        applyStimulus(idle, "sq_after");
        checkVal("sq_after.stall_delta", 64'(stall_cycles) - 64'(base), 64'd5);
        checkVal("sq_after.redirect_pc", 64'(redirect_pc), 64'hDEAD_0000);

        // Branch held under a memory freeze is deferred until the freeze clears.
        base = m_flush;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkStim(1, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0300), "frz_br");
            checkVal("frz_br.loads", 64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 64'd0);
        end
        applyStimulus(mkStim(1, 1, 1, 0, 0, 0, 0, 1, 32'h0000_0300), "frz_release");
        checkVal("frz_release.pc_redirect", 64'(pc_redirect), 64'd1);
        checkVal("frz_release.redirect_pc", 64'(redirect_pc), 64'h300);
        applyStimulus(idle, "frz_after");
        checkVal("frz_after.flush_delta", 64'(flush_count) - 64'(base), 64'd1);

        // Reset in the middle of a squash discards the pending redirect.
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0400), "rst_sq_enter");
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_7777), "rst_sq_wait");
        holdReset(2, mkStim(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_7777), "rst_mid_sq");
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_7777), "rst_release");
        checkVal("rst_release.pc_redirect", 64'(pc_redirect), 64'd0);
        checkVal("rst_release.redirect_pc", 64'(redirect_pc), 64'h7777);

        // Random traffic; no branch is offered while a redirect is pending.
        for (int i = 0; i < 400; i++) begin
            s.imem_resp   = ($urandom_range(0, 3) != 0);
            s.dmem_req    = ($urandom_range(0, 2) == 0);
            s.dmem_resp   = ($urandom_range(0, 2) != 0);
            s.ex_mem_read = ($urandom_range(0, 1) == 0);
            s.ex_rd       = 5'($urandom_range(0, 3));
            s.id_rs1      = 5'($urandom_range(0, 3));
            s.id_rs2      = 5'($urandom_range(0, 3));
            s.br_taken    = !m_pending && ($urandom_range(0, 4) == 0);
            s.br_target   = $urandom;
            applyStimulus(s, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
